// File: rtl/sdram_rr_arbiter.sv
`default_nettype none
//==============================================================================
// Module   : sdram_rr_arbiter
// Brief    : Round-robin arbiter sharing one Avalon master between two readers
//            and one writer, with write override and an ack watchdog.
// Revision : 1.0 - initial release
//==============================================================================
module sdram_rr_arbiter #(
  parameter int ADDR_W  = 26,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk50,
  input  logic              reset,
  input  logic              wr_override,
  input  logic              rd_req_0,
  input  logic [ADDR_W-1:0] rd_addr_0,
  output logic              rd_ack_0,
  output logic [DATA_W-1:0] rd_data_0,
  input  logic              rd_req_1,
  input  logic [ADDR_W-1:0] rd_addr_1,
  output logic              rd_ack_1,
  output logic [DATA_W-1:0] rd_data_1,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic [ADDR_W-1:0] avl_addr,
  output logic              avl_read,
  output logic              avl_write,
  output logic [DATA_W-1:0] avl_wrdata,
  input  logic [DATA_W-1:0] avl_rddata,
  input  logic              avl_ack,
  output logic [1:0]        grant_id,
  output logic              timeout_err
);

  localparam int              c_wd_w     = $clog2(TIMEOUT + 1);
  localparam logic [c_wd_w-1:0] c_wd_limit = c_wd_w'(TIMEOUT);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_xfer = 2'd1;
  localparam logic [1:0] c_st_done = 2'd2;

  localparam logic [1:0] c_id_rd0  = 2'd0;
  localparam logic [1:0] c_id_rd1  = 2'd1;
  localparam logic [1:0] c_id_wr   = 2'd2;
  localparam logic [1:0] c_id_none = 2'd3;

  logic [1:0]        r_state;
  logic [1:0]        w_next_state;
  logic [1:0]        r_owner;
  logic [1:0]        r_ptr;
  logic [c_wd_w-1:0] r_wd;
  logic [ADDR_W-1:0] r_avl_addr;
  logic [DATA_W-1:0] r_avl_wrdata;
  logic [DATA_W-1:0] r_rd_data_0;
  logic [DATA_W-1:0] r_rd_data_1;
  logic              r_timeout_err;

  logic [2:0]        w_cand;
  logic [1:0]        w_win_id;
  logic              w_win_valid;
  logic [ADDR_W-1:0] w_win_addr;
  logic              w_expired;
  logic              w_xfer_end;
  logic [DATA_W-1:0] w_cap_data;

  // Override masks the readers out of the candidate set entirely.
  assign w_cand = {wr_req, rd_req_1 & ~wr_override, rd_req_0 & ~wr_override};

  always_comb begin
    w_win_valid = 1'b1;
    w_win_id    = c_id_rd0;
    case (r_ptr)
      c_id_rd1: begin
        if (w_cand[1])      w_win_id = c_id_rd1;
        else if (w_cand[2]) w_win_id = c_id_wr;
        else if (w_cand[0]) w_win_id = c_id_rd0;
        else                w_win_valid = 1'b0;
      end
      c_id_wr: begin
        if (w_cand[2])      w_win_id = c_id_wr;
        else if (w_cand[0]) w_win_id = c_id_rd0;
        else if (w_cand[1]) w_win_id = c_id_rd1;
        else                w_win_valid = 1'b0;
      end
      default: begin
        if (w_cand[0])      w_win_id = c_id_rd0;
        else if (w_cand[1]) w_win_id = c_id_rd1;
        else if (w_cand[2]) w_win_id = c_id_wr;
        else                w_win_valid = 1'b0;
      end
    endcase
  end

  always_comb begin
    w_win_addr = rd_addr_0;
    case (w_win_id)
      c_id_rd1: w_win_addr = rd_addr_1;
      c_id_wr:  w_win_addr = wr_addr;
      default:  w_win_addr = rd_addr_0;
    endcase
  end

  assign w_expired  = (r_wd == c_wd_limit);
  assign w_xfer_end = avl_ack | w_expired;
  assign w_cap_data = avl_ack ? avl_rddata : '0;

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) r_state <= c_st_idle;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_st_idle: if (w_win_valid) w_next_state = c_st_xfer;
      c_st_xfer: if (w_xfer_end)  w_next_state = c_st_done;
      default:   w_next_state = c_st_idle;
    endcase
  end

  // Strobes, grant and acks decode straight from state so reset drops them at once.
  always_comb begin
    avl_read  = 1'b0;
    avl_write = 1'b0;
    grant_id  = c_id_none;
    rd_ack_0  = 1'b0;
    rd_ack_1  = 1'b0;
    wr_ack    = 1'b0;
    case (r_state)
      c_st_xfer: begin
        grant_id  = r_owner;
        avl_read  = (r_owner != c_id_wr);
        avl_write = (r_owner == c_id_wr);
      end
      c_st_done: begin
        rd_ack_0 = (r_owner == c_id_rd0);
        rd_ack_1 = (r_owner == c_id_rd1);
        wr_ack   = (r_owner == c_id_wr);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      r_owner       <= c_id_none;
      r_ptr         <= c_id_rd0;
      r_wd          <= '0;
      r_avl_addr    <= '0;
      r_avl_wrdata  <= '0;
      r_rd_data_0   <= '0;
      r_rd_data_1   <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (w_win_valid) begin
            r_owner    <= w_win_id;
            r_ptr      <= (w_win_id == c_id_wr) ? c_id_rd0 : w_win_id + 2'd1;
            r_wd       <= '0;
            r_avl_addr <= w_win_addr;
            if (w_win_id == c_id_wr) r_avl_wrdata <= wr_data;
          end
        end
        c_st_xfer: begin
          if (w_xfer_end) begin
            if (r_owner == c_id_rd0) r_rd_data_0 <= w_cap_data;
            if (r_owner == c_id_rd1) r_rd_data_1 <= w_cap_data;
            if (!avl_ack)            r_timeout_err <= 1'b1;
          end else begin
            r_wd <= r_wd + c_wd_w'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign avl_addr    = r_avl_addr;
  assign avl_wrdata  = r_avl_wrdata;
  assign rd_data_0   = r_rd_data_0;
  assign rd_data_1   = r_rd_data_1;
  assign timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_sdram_rr_arbiter.sv
`default_nettype none
//==============================================================================
// Module   : tb_sdram_rr_arbiter
// Brief    : Self-checking bench: bridge model, monitor and arbitration model.
// Revision : 1.0 - initial release
//==============================================================================
module tb_sdram_rr_arbiter;
  localparam int AW = 26;
  localparam int DW = 16;
  localparam int TO = 8;

  logic          clk50 = 1'b0;
  logic          reset = 1'b1;
  logic          wr_override = 1'b0;
  logic          rd_req_0 = 1'b0, rd_req_1 = 1'b0, wr_req = 1'b0;
  logic [AW-1:0] rd_addr_0 = '0, rd_addr_1 = '0, wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_ack_0, rd_ack_1, wr_ack;
  logic [DW-1:0] rd_data_0, rd_data_1;
  logic [AW-1:0] avl_addr;
  logic          avl_read, avl_write;
  logic [DW-1:0] avl_wrdata;
  logic [DW-1:0] avl_rddata = '0;
  logic          avl_ack = 1'b0;
  logic [1:0]    grant_id;
  logic          timeout_err;

  typedef struct {
    logic [2:0] mask; logic ovr;
    logic [AW-1:0] a0, a1, aw; logic [DW-1:0] wd;
    logic [1:0] gid; logic [AW-1:0] addr; logic [DW-1:0] wdata;
    logic rd, wr; int cyc;
  } grant_t;
  typedef struct { int port; logic [DW-1:0] data; int cyc; } ack_t;

  grant_t gq[$];
  ack_t   aq[$];
  int     len_q[$];

  int total = 0, bad = 0, cyc = 0, inv_viol = 0, m_ptr = 0;
  int bridge_lat = 4, br_cnt = 0, mon_len = 0;
  bit use_fixed = 1'b0;
  logic [DW-1:0] fixed_val = '0;
  bit hold [3] = '{1'b0, 1'b0, 1'b0};
  logic mon_prev = 1'b0;
  grant_t mon_g;
  ack_t   mon_a;

  sdram_rr_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk50(clk50), .reset(reset), .wr_override(wr_override),
    .rd_req_0(rd_req_0), .rd_addr_0(rd_addr_0), .rd_ack_0(rd_ack_0), .rd_data_0(rd_data_0),
    .rd_req_1(rd_req_1), .rd_addr_1(rd_addr_1), .rd_ack_1(rd_ack_1), .rd_data_1(rd_data_1),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .avl_addr(avl_addr), .avl_read(avl_read), .avl_write(avl_write), .avl_wrdata(avl_wrdata),
    .avl_rddata(avl_rddata), .avl_ack(avl_ack), .grant_id(grant_id), .timeout_err(timeout_err)
  );

  always #10 clk50 = ~clk50;
  always @(posedge clk50) cyc <= cyc + 1;

  function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
    return a[15:0] ^ {a[25:16], 6'h15} ^ 16'h5A3C;
  endfunction

  function automatic logic [AW-1:0] rand_addr();
    return AW'($urandom()) & ~AW'(1);
  endfunction

  // Reference arbitration: first eligible requester searching cyclically from m_ptr.
  function automatic int model_pick(input logic [2:0] mask, input logic ovr);
    for (int i = 0; i < 3; i++) begin
      int p;
      p = (m_ptr + i) % 3;
      if (mask[p] && (!ovr || p == 2)) return p;
    end
    return -1;
  endfunction

  // Bridge: acks after bridge_lat strobe cycles; latency 0 means never ack.
  initial begin
    forever begin
      @(posedge clk50); #1;
      if (avl_ack) begin
        avl_ack = 1'b0; br_cnt = 0;
      end else if ((avl_read || avl_write) && !reset) begin
        br_cnt++;
        if (bridge_lat != 0 && br_cnt == bridge_lat) begin
          avl_ack = 1'b1;
          avl_rddata = use_fixed ? fixed_val : mem_fn(avl_addr);
        end
      end else begin
        br_cnt = 0;
      end
    end
  end

  always begin
    @(posedge clk50); #1;
    if (avl_read && avl_write) inv_viol++;
    if (int'(rd_ack_0) + int'(rd_ack_1) + int'(wr_ack) > 1) inv_viol++;
    if ((avl_read || avl_write) && !mon_prev) begin
      mon_g.mask = {wr_req, rd_req_1, rd_req_0}; mon_g.ovr = wr_override;
      mon_g.a0 = rd_addr_0; mon_g.a1 = rd_addr_1; mon_g.aw = wr_addr; mon_g.wd = wr_data;
      mon_g.gid = grant_id; mon_g.addr = avl_addr; mon_g.wdata = avl_wrdata;
      mon_g.rd = avl_read; mon_g.wr = avl_write; mon_g.cyc = cyc;
      gq.push_back(mon_g);
      mon_len = 0;
    end
    if (avl_read || avl_write) mon_len++;
    else if (mon_prev) len_q.push_back(mon_len);
    mon_prev = avl_read || avl_write;
    if (rd_ack_0) begin mon_a.port = 0; mon_a.data = rd_data_0; mon_a.cyc = cyc; aq.push_back(mon_a); end
    if (rd_ack_1) begin mon_a.port = 1; mon_a.data = rd_data_1; mon_a.cyc = cyc; aq.push_back(mon_a); end
    if (wr_ack)   begin mon_a.port = 2; mon_a.data = '0;        mon_a.cyc = cyc; aq.push_back(mon_a); end
  end

  task automatic clear_logs();
    gq.delete(); aq.delete(); len_q.delete();
  endtask

  task automatic drop_all();
    rd_req_0 = 1'b0; rd_req_1 = 1'b0; wr_req = 1'b0; wr_override = 1'b0;
    hold = '{1'b0, 1'b0, 1'b0};
  endtask

  // Requester behaviour: on ack, present a new address (hold) or drop the request.
  task automatic drive(input int n, input int budget, input bit rnd, output int got);
    int start;
    start = aq.size();
    for (int c = 0; c < budget && (aq.size() - start) < n; c++) begin
      @(posedge clk50); #2;
      if (rd_ack_0) begin if (hold[0]) rd_addr_0 = rand_addr(); else rd_req_0 = 1'b0; end
      if (rd_ack_1) begin if (hold[1]) rd_addr_1 = rand_addr(); else rd_req_1 = 1'b0; end
      if (wr_ack) begin
        if (hold[2]) begin wr_addr = rand_addr(); wr_data = DW'($urandom()); end
        else wr_req = 1'b0;
      end
      if (rnd) begin
        if (!rd_req_0 && $urandom_range(0, 2) == 0) begin rd_req_0 = 1'b1; rd_addr_0 = rand_addr(); end
        if (!rd_req_1 && $urandom_range(0, 2) == 0) begin rd_req_1 = 1'b1; rd_addr_1 = rand_addr(); end
        if (!wr_req && $urandom_range(0, 2) == 0) begin
          wr_req = 1'b1; wr_addr = rand_addr(); wr_data = DW'($urandom());
        end
        if ($urandom_range(0, 11) == 0) wr_override = ~wr_override;
        if (!avl_read && !avl_write) bridge_lat = $urandom_range(1, 4);
      end
    end
    got = aq.size() - start;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk50);
    #1;
    total++; if (avl_read !== 1'b0) begin bad++; $display("FAIL reset_avl_read got=%b want=0", avl_read); end
    total++; if (avl_write !== 1'b0) begin bad++; $display("FAIL reset_avl_write got=%b want=0", avl_write); end
    total++; if (avl_addr !== '0) begin bad++; $display("FAIL reset_avl_addr got=%h want=0", avl_addr); end
    total++; if (avl_wrdata !== '0) begin bad++; $display("FAIL reset_avl_wrdata got=%h want=0", avl_wrdata); end
    total++; if ({rd_ack_0, rd_ack_1, wr_ack} !== 3'b000) begin bad++; $display("FAIL reset_acks got=%b want=000", {rd_ack_0, rd_ack_1, wr_ack}); end
    total++; if (rd_data_0 !== '0 || rd_data_1 !== '0) begin bad++; $display("FAIL reset_rd_data got=%h/%h want=0/0", rd_data_0, rd_data_1); end
    total++; if (grant_id !== 2'd3) begin bad++; $display("FAIL reset_grant_id got=%0d want=3", grant_id); end
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL reset_timeout_err got=%b want=0", timeout_err); end
    @(negedge clk50); reset = 1'b0;
    m_ptr = 0;
  endtask

  task automatic test_single_read();
    int got, e;
    clear_logs();
    bridge_lat = 4; use_fixed = 1'b1; fixed_val = 16'hBEEF;
    @(posedge clk50); #2;
    rd_addr_0 = 26'h000010; rd_req_0 = 1'b1;
    drive(1, 60, 1'b0, got);
    e = model_pick(3'b001, 1'b0); m_ptr = (e + 1) % 3;
    total++; if (got !== 1 || gq.size() !== 1) begin bad++; $display("FAIL single_count acks=%0d grants=%0d want=1/1", got, gq.size()); end
    if (got == 1 && gq.size() == 1 && len_q.size() > 0) begin
      total++; if (gq[0].gid !== 2'(e) || gq[0].rd !== 1'b1 || gq[0].wr !== 1'b0) begin bad++; $display("FAIL single_grant gid=%0d rd=%b wr=%b want=%0d/1/0", gq[0].gid, gq[0].rd, gq[0].wr, e); end
      total++; if (gq[0].addr !== 26'h10) begin bad++; $display("FAIL single_addr got=%h want=10", gq[0].addr); end
      total++; if (len_q[0] !== 4) begin bad++; $display("FAIL single_strobe_len got=%0d want=4", len_q[0]); end
      total++; if (aq[0].port !== 0 || aq[0].data !== 16'hBEEF) begin bad++; $display("FAIL single_ack port=%0d data=%h want=0/beef", aq[0].port, aq[0].data); end
      total++; if (aq[0].cyc - gq[0].cyc !== 4) begin bad++; $display("FAIL single_latency got=%0d want=4", aq[0].cyc - gq[0].cyc); end
    end
    total++; if (grant_id !== 2'd3) begin bad++; $display("FAIL single_grant_release got=%0d want=3", grant_id); end
    @(posedge clk50); #2;
    total++; if (rd_data_0 !== 16'hBEEF || rd_data_1 !== '0 || rd_ack_0 !== 1'b0) begin bad++; $display("FAIL single_hold d0=%h d1=%h ack=%b want=beef/0/0", rd_data_0, rd_data_1, rd_ack_0); end
    use_fixed = 1'b0;
  endtask

  task automatic test_fairness();
    int got, e, prev;
    logic [AW-1:0] ea;
    clear_logs();
    bridge_lat = 2; prev = -1;
    @(posedge clk50); #2;
    rd_addr_0 = rand_addr(); rd_addr_1 = rand_addr(); wr_addr = rand_addr(); wr_data = DW'($urandom());
    rd_req_0 = 1'b1; rd_req_1 = 1'b1; wr_req = 1'b1; hold = '{1'b1, 1'b1, 1'b1};
    drive(6, 200, 1'b0, got);
    drop_all();
    total++; if (got !== 6) begin bad++; $display("FAIL fair_count got=%0d want=6", got); end
    for (int i = 0; i < 6; i++) begin
      if (i < gq.size() && i < aq.size()) begin
        e = model_pick(3'b111, 1'b0); m_ptr = (e + 1) % 3;
        ea = (e == 0) ? gq[i].a0 : (e == 1) ? gq[i].a1 : gq[i].aw;
        total++; if (gq[i].gid !== 2'(e) || gq[i].addr !== ea) begin bad++; $display("FAIL fair_grant[%0d] gid=%0d addr=%h want=%0d/%h", i, gq[i].gid, gq[i].addr, e, ea); end
        total++; if (int'(gq[i].gid) == prev) begin bad++; $display("FAIL fair_repeat[%0d] gid=%0d twice", i, gq[i].gid); end
        total++; if (aq[i].port !== e || (e != 2 && aq[i].data !== mem_fn(ea))) begin bad++; $display("FAIL fair_ack[%0d] port=%0d data=%h want=%0d/%h", i, aq[i].port, aq[i].data, e, mem_fn(ea)); end
        prev = int'(gq[i].gid);
      end
    end
  endtask

  task automatic test_override();
    int got, e;
    clear_logs();
    bridge_lat = 2;
    @(posedge clk50); #2;
    wr_override = 1'b1; wr_addr = rand_addr(); wr_data = DW'($urandom());
    rd_req_0 = 1'b1; rd_req_1 = 1'b1; wr_req = 1'b1; hold = '{1'b1, 1'b1, 1'b1};
    drive(3, 150, 1'b0, got);
    wr_override = 1'b0;
    drive(1, 60, 1'b0, got);
    drop_all();
    total++; if (aq.size() !== 4) begin bad++; $display("FAIL ovr_count got=%0d want=4", aq.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < gq.size() && i < aq.size()) begin
        e = model_pick(3'b111, i < 3); m_ptr = (e + 1) % 3;
        total++; if (gq[i].gid !== 2'(e) || aq[i].port !== e) begin bad++; $display("FAIL ovr_grant[%0d] gid=%0d ack=%0d want=%0d", i, gq[i].gid, aq[i].port, e); end
        if (e == 2) begin
          total++; if (gq[i].wr !== 1'b1 || gq[i].wdata !== gq[i].wd || gq[i].addr !== gq[i].aw) begin bad++; $display("FAIL ovr_write[%0d] wr=%b data=%h addr=%h want=1/%h/%h", i, gq[i].wr, gq[i].wdata, gq[i].addr, gq[i].wd, gq[i].aw); end
        end
      end
    end
  endtask

  task automatic test_override_mid_read();
    int got, e1, e2;
    bit seen;
    clear_logs();
    bridge_lat = 5; seen = 1'b0;
    @(posedge clk50); #2;
    rd_addr_1 = rand_addr(); rd_req_1 = 1'b1;
    for (int c = 0; c < 20 && !seen; c++) begin @(posedge clk50); #2; seen = avl_read; end
    total++; if (!seen) begin bad++; $display("FAIL ovr_mid_strobe got=0 want=1"); end
    wr_override = 1'b1; wr_req = 1'b1; wr_addr = rand_addr(); rd_req_0 = 1'b1; rd_addr_0 = rand_addr();
    drive(2, 80, 1'b0, got);
    drop_all();
    e1 = model_pick(3'b010, 1'b0); m_ptr = (e1 + 1) % 3;
    e2 = model_pick(3'b111, 1'b1); m_ptr = (e2 + 1) % 3;
    total++; if (got !== 2 || gq.size() < 2) begin bad++; $display("FAIL ovr_mid_count acks=%0d grants=%0d want=2/2", got, gq.size()); end
    if (aq.size() >= 2 && gq.size() >= 2) begin
      total++; if (aq[0].port !== e1 || aq[0].data !== mem_fn(gq[0].a1)) begin bad++; $display("FAIL ovr_mid_read port=%0d data=%h want=%0d/%h", aq[0].port, aq[0].data, e1, mem_fn(gq[0].a1)); end
      total++; if (gq[1].gid !== 2'(e2) || aq[1].port !== e2) begin bad++; $display("FAIL ovr_mid_next gid=%0d ack=%0d want=%0d", gq[1].gid, aq[1].port, e2); end
    end
  endtask

  task automatic test_timeout();
    int got, e;
    clear_logs();
    bridge_lat = 0;
    @(posedge clk50); #2;
    rd_addr_0 = rand_addr(); rd_req_0 = 1'b1;
    drive(1, 60, 1'b0, got);
    e = model_pick(3'b001, 1'b0); m_ptr = (e + 1) % 3;
    total++; if (got !== 1 || gq.size() !== 1 || len_q.size() !== 1) begin bad++; $display("FAIL to_count acks=%0d grants=%0d want=1/1", got, gq.size()); end
    if (got == 1 && gq.size() == 1 && len_q.size() == 1) begin
      total++; if (len_q[0] !== TO + 1) begin bad++; $display("FAIL to_strobe_len got=%0d want=%0d", len_q[0], TO + 1); end
      total++; if (aq[0].cyc - gq[0].cyc !== TO + 1) begin bad++; $display("FAIL to_ack_time got=%0d want=%0d", aq[0].cyc - gq[0].cyc, TO + 1); end
      total++; if (aq[0].port !== e || aq[0].data !== '0) begin bad++; $display("FAIL to_ack port=%0d data=%h want=%0d/0", aq[0].port, aq[0].data, e); end
    end
    total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL to_flag got=%b want=1", timeout_err); end
    clear_logs();
    bridge_lat = 3; use_fixed = 1'b1; fixed_val = 16'h1234;
    rd_addr_1 = rand_addr(); rd_req_1 = 1'b1;
    drive(1, 60, 1'b0, got);
    e = model_pick(3'b010, 1'b0); m_ptr = (e + 1) % 3;
    use_fixed = 1'b0;
    total++; if (got !== 1 || aq.size() < 1) begin bad++; $display("FAIL to_next_count got=%0d want=1", got); end
    if (aq.size() >= 1) begin
      total++; if (aq[0].port !== e || aq[0].data !== 16'h1234) begin bad++; $display("FAIL to_next_ack port=%0d data=%h want=%0d/1234", aq[0].port, aq[0].data, e); end
    end
    total++; if (timeout_err !== 1'b1 || rd_data_0 !== '0) begin bad++; $display("FAIL to_sticky err=%b d0=%h want=1/0", timeout_err, rd_data_0); end
  endtask

  task automatic test_reset_mid_xfer();
    int got, n_ack;
    bit seen;
    clear_logs();
    bridge_lat = 0; seen = 1'b0;
    @(posedge clk50); #2;
    wr_addr = rand_addr() | AW'(2); wr_data = DW'($urandom()) | 16'h0001; wr_req = 1'b1;
    for (int c = 0; c < 20 && !seen; c++) begin @(posedge clk50); #2; seen = avl_write; end
    total++; if (!seen) begin bad++; $display("FAIL rst_mid_strobe got=0 want=1"); end
    repeat (3) @(posedge clk50);
    n_ack = aq.size();
    #5 reset = 1'b1;
    #1;
    total++; if (avl_write !== 1'b0 || grant_id !== 2'd3) begin bad++; $display("FAIL rst_mid_async write=%b gid=%0d want=0/3", avl_write, grant_id); end
    total++; if (avl_addr !== '0 || avl_wrdata !== '0) begin bad++; $display("FAIL rst_mid_bus addr=%h data=%h want=0/0", avl_addr, avl_wrdata); end
    total++; if (rd_data_0 !== '0 || rd_data_1 !== '0 || timeout_err !== 1'b0) begin bad++; $display("FAIL rst_mid_regs d0=%h d1=%h err=%b want=0/0/0", rd_data_0, rd_data_1, timeout_err); end
    wr_req = 1'b0;
    repeat (2) @(posedge clk50);
    @(negedge clk50); reset = 1'b0;
    m_ptr = 0;
    @(posedge clk50); #2;
    total++; if (aq.size() !== n_ack) begin bad++; $display("FAIL rst_mid_no_ack acks=%0d want=%0d", aq.size(), n_ack); end
    clear_logs();
    bridge_lat = 2;
    rd_addr_0 = rand_addr(); rd_addr_1 = rand_addr(); wr_addr = rand_addr();
    rd_req_0 = 1'b1; rd_req_1 = 1'b1; wr_req = 1'b1;
    drive(1, 60, 1'b0, got);
    drop_all();
    total++; if (gq.size() < 1 || gq[0].gid !== 2'(model_pick(3'b111, 1'b0))) begin bad++; $display("FAIL rst_mid_first grants=%0d gid=%0d want=rd0", gq.size(), gq.size() > 0 ? gq[0].gid : 2'd3); end
    m_ptr = 1;
  endtask

  task automatic test_random();
    int got, e;
    logic [AW-1:0] ea;
    clear_logs();
    bridge_lat = 2;
    drive(40, 4000, 1'b1, got);
    drop_all();
    repeat (4) @(posedge clk50);
    total++; if (got !== 40 || gq.size() !== aq.size()) begin bad++; $display("FAIL rand_count acks=%0d grants=%0d want=40/40", got, gq.size()); end
    for (int i = 0; i < gq.size() && i < aq.size(); i++) begin
      e = model_pick(gq[i].mask, gq[i].ovr);
      if (e >= 0) m_ptr = (e + 1) % 3;
      ea = (e == 0) ? gq[i].a0 : (e == 1) ? gq[i].a1 : gq[i].aw;
      total++; if (int'(gq[i].gid) !== e || gq[i].addr !== ea) begin bad++; $display("FAIL rand_grant[%0d] gid=%0d addr=%h want=%0d/%h", i, gq[i].gid, gq[i].addr, e, ea); end
      total++; if (aq[i].port !== e) begin bad++; $display("FAIL rand_ack_port[%0d] got=%0d want=%0d", i, aq[i].port, e); end
      if (e == 2) begin
        total++; if (gq[i].wr !== 1'b1 || gq[i].rd !== 1'b0 || gq[i].wdata !== gq[i].wd) begin bad++; $display("FAIL rand_write[%0d] wr=%b rd=%b data=%h want=1/0/%h", i, gq[i].wr, gq[i].rd, gq[i].wdata, gq[i].wd); end
      end else begin
        total++; if (gq[i].rd !== 1'b1 || aq[i].data !== mem_fn(ea)) begin bad++; $display("FAIL rand_read[%0d] rd=%b data=%h want=1/%h", i, gq[i].rd, aq[i].data, mem_fn(ea)); end
      end
    end
  endtask

  task automatic test_invariants();
    total++; if (inv_viol !== 0) begin bad++; $display("FAIL invariants violations=%0d want=0", inv_viol); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_fairness();
    test_override();
    test_override_mid_read();
    test_timeout();
    test_reset_mid_xfer();
    test_random();
    test_invariants();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
